wb_debug_bridge: RTL and testbench
==================================

// Module: wb_debug_bridge
// PURPOSE
//  Byte-stream-to-Wishbone debug master. Consumes bytes from a UART receiver core and
//  issues single 32-bit Wishbone classic transactions on the SoC bus.
//  Sits upstream of the bus address decode, as the second master behind the arbiter.
//  Also drives the CPU halt line for load/inspect sessions.
// PARAMETERS
//  TIMEOUT_CYCLES  1024   bus cycles to wait for ack_i before abort (>=2)
//  ACK_BYTE        8'h06  response byte for completed write/halt command
//  NAK_BYTE        8'h15  response byte for bad command or bus timeout
//  HALT_RESET_VAL  1'b0   reset value of cpu_halt_o
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous, active-high reset
//  rx_valid_i  in   1   one-cycle strobe: rx_data_i holds a received byte
//  rx_data_i   in   8   received byte
//  tx_valid_o  out  1   response byte available
//  tx_data_o   out  8   response byte; stable while tx_valid_o && !tx_ready_i
//  tx_ready_i  in   1   transmitter accepts byte when tx_valid_o && tx_ready_i
//  cyc_o/stb_o out  1   Wishbone cycle/strobe (always equal)
//  we_o        out  1   Wishbone write enable
//  addr_o      out  32  Wishbone address
//  data_o      out  32  Wishbone write data
//  data_i      in   32  Wishbone read data
//  ack_i       in   1   Wishbone acknowledge
//  busy_o      out  1   high whenever state != IDLE
//  cpu_halt_o  out  1   processor halt request
// BEHAVIOUR
//  One clock (clk); reset is synchronous and active-high (rst). Reset: state=IDLE, all outputs 0
//  except cpu_halt_o=HALT_RESET_VAL. Counters and shift registers are cleared.
//  Reset mid-transaction drops cyc/stb the next cycle. A pending tx byte is discarded.
//  Commands: 'W'(8'h57)+A3..A0+D3..D0 | 'R'(8'h52)+A3..A0 | 'H'(8'h48)+B. Multi-byte
//  fields are sent MSB first.
//  FSM: IDLE -> cmd byte. On W/R go to ADDR; on H go to HALT; any other byte loads NAK_BYTE and goes to RESP.
//   ADDR: shift 4 bytes into addr_o (2-bit counter). After the 4th byte, R goes to BUS and W goes to DATA.
//   DATA: shift 4 bytes into data_o. After the 4th byte go to BUS.
//   HALT: next byte sets cpu_halt_o<=B[0] in the same cycle, loads ACK_BYTE, and goes to RESP.
//   BUS: cyc_o=stb_o=1 from the cycle after the last byte was accepted; we_o=1 for W.
//    addr_o, data_o and we_o are stable throughout BUS.
//    When ack_i is sampled high, cyc/stb drop on the next cycle. On R, data_i is latched into a 4-byte response.
//    On W, ACK_BYTE is loaded. Then go to RESP. A combinational ack_i in the first BUS cycle is legal (1-cycle bus).
//   RESP: present response bytes one at a time. Advance on tx_valid_o && tx_ready_i.
//    Return to IDLE the cycle after the final handshake. R sends 4 bytes MSB first; all others send 1 byte.
//  rx bytes arriving in BUS or RESP are dropped (no backpressure on rx).
//  No inter-byte timeout in ADDR/DATA; a partial frame waits indefinitely. Reset resynchronises.
//  cpu_halt_o only changes via the H command or reset; R/W work with the CPU running or halted.
// CONFIGURATION
//  WB_DEBUG_BRIDGE_TIMEOUT_EN defined:
//   - A 16-bit counter is cleared on BUS entry and increments each BUS cycle without ack_i.
//   - When it reaches TIMEOUT_CYCLES-1 with no ack, cyc/stb drop on the next cycle and the
//     response is NAK_BYTE (1 byte, for R and W alike).
//   - An ack arriving in that same cycle wins.
//  Undefined: BUS waits for ack_i indefinitely; no counter logic is synthesised.
// STRUCTURE
//  Package wb_debug_bridge_pkg:
//   - state enum (IDLE, ADDR, DATA, HALT, BUS, RESP)
//   - CMD_WRITE/CMD_READ/CMD_HALT byte constants
//  Sub-module wb_debug_bridge_tx_ser:
//   - 32-bit load, 1..4-byte count
//   - valid/ready shift-out, MSB first
//   - done pulse on the final handshake
//  The FSM and Wishbone logic stay in the top module.
// TESTING
//  1. Rx 57 80000000 000000A5, ack_i 2 cycles after stb:
//     one write (addr 32'h80000000, data 32'hA5, we_o=1) -> tx 06, busy_o low.
//  2. Rx 52 00000010, slave returns 32'hDEADBEEF with a 0-wait ack ->
//     tx DE AD BE EF in order, with tx_ready_i toggled 1/0 per cycle.
//  3. Rx 48 01 then 48 00 -> cpu_halt_o 1 then 0, tx 06 each time.
//     Rx 7A -> tx 15, no bus cycle.
//  4. TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks, rx R frame ->
//     stb high exactly 8 cycles, then tx 15.
//     Undefined macro -> stb stays high.
//  5. Rst asserted during BUS and during RESP -> next cycle cyc_o=0, tx_valid_o=0, state IDLE.
//     A new W frame then completes normally.
//  6. Rx bytes injected during BUS/RESP -> ignored.
//     The following valid frame decodes correctly.

Source files
------------

// File: rtl/wb_debug_bridge_pkg.sv
// Shared state encoding and command bytes for the UART-to-Wishbone debug bridge.
package wb_debug_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_HALT = 3'd3,
        ST_BUS  = 3'd4,
        ST_RESP = 3'd5
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_HALT  = 8'h48;

endpackage

// File: rtl/wb_debug_bridge_tx_ser.sv
// Response serialiser: loads a left-aligned word plus a 1..4 byte count and shifts it out MSB first.
// First byte is valid the cycle after load; each byte holds until tx_ready, done pulses on the last handshake.
module wb_debug_bridge_tx_ser (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_data,
    input  logic [2:0]  i_count,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [7:0]  o_data,
    output logic        o_done
);

    logic [31:0] r_shift;
    logic [2:0]  r_left;
    logic        w_hs;

    assign o_valid = (r_left != 3'd0);
    assign o_data  = r_shift[31:24];
    assign w_hs    = o_valid && i_ready;
    assign o_done  = w_hs && (r_left == 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= 32'h0;
            r_left  <= 3'd0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_left  <= i_count;
        end else if (w_hs) begin
            r_shift <= {r_shift[23:0], 8'h00};
            r_left  <= r_left - 3'd1;
        end
    end

endmodule

// File: rtl/wb_debug_bridge.sv
// Byte-stream Wishbone debug master with CPU halt control; no rx backpressure, tx is valid/ready.
// Optional bus timeout with NAK response when WB_DEBUG_BRIDGE_TIMEOUT_EN is defined.
module wb_debug_bridge
    import wb_debug_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15,
    parameter logic        HALT_RESET_VAL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    input  logic        ack_i,
    output logic        busy_o,
    output logic        cpu_halt_o
);

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_cyc;
    logic        r_we;
    logic        r_halt;

    logic        w_ld;
    logic [31:0] w_ld_dat;
    logic [2:0]  w_ld_cnt;
    logic        w_tx_done;
    logic        w_to_hit;

`ifdef WB_DEBUG_BRIDGE_TIMEOUT_EN
    logic [15:0] r_to;

    // Held at zero outside BUS so every bus cycle starts a fresh window.
    always_ff @(posedge clk) begin
        if (rst || r_state != ST_BUS) begin
            r_to <= 16'h0;
        end else if (!ack_i) begin
            r_to <= r_to + 16'h1;
        end
    end

    assign w_to_hit = (r_to == 16'(TIMEOUT_CYCLES - 1));
`else
    assign w_to_hit = 1'b0;
`endif

    assign cyc_o      = r_cyc;
    assign stb_o      = r_cyc;
    assign we_o       = r_cyc & r_we;
    assign addr_o     = r_addr;
    assign data_o     = r_data;
    assign busy_o     = (r_state != ST_IDLE);
    assign cpu_halt_o = r_halt;

    always_comb begin
        w_ld     = 1'b0;
        w_ld_dat = 32'h0;
        w_ld_cnt = 3'd1;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid_i && rx_data_i != CMD_WRITE && rx_data_i != CMD_READ
                    && rx_data_i != CMD_HALT) begin
                    w_ld     = 1'b1;
                    w_ld_dat = {NAK_BYTE, 24'h0};
                end
            end
            ST_HALT: begin
                if (rx_valid_i) begin
                    w_ld     = 1'b1;
                    w_ld_dat = {ACK_BYTE, 24'h0};
                end
            end
            ST_BUS: begin
                if (ack_i) begin
                    w_ld     = 1'b1;
                    w_ld_dat = r_we ? {ACK_BYTE, 24'h0} : data_i;
                    w_ld_cnt = r_we ? 3'd1 : 3'd4;
                end else if (w_to_hit) begin
                    w_ld     = 1'b1;
                    w_ld_dat = {NAK_BYTE, 24'h0};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_addr  <= 32'h0;
            r_data  <= 32'h0;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_halt  <= HALT_RESET_VAL;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 2'd0;
                    if (rx_valid_i) begin
                        r_we <= (rx_data_i == CMD_WRITE);
                        if (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ) begin
                            r_state <= ST_ADDR;
                        end else if (rx_data_i == CMD_HALT) begin
                            r_state <= ST_HALT;
                        end else begin
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_valid_i) begin
                        r_addr <= {r_addr[23:0], rx_data_i};
                        r_cnt  <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            if (r_we) begin
                                r_state <= ST_DATA;
                            end else begin
                                r_state <= ST_BUS;
                                r_cyc   <= 1'b1;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_valid_i) begin
                        r_data <= {r_data[23:0], rx_data_i};
                        r_cnt  <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= ST_BUS;
                            r_cyc   <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (rx_valid_i) begin
                        r_halt  <= rx_data_i[0];
                        r_state <= ST_RESP;
                    end
                end
                ST_BUS: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (ack_i || w_to_hit) begin
                        r_cyc   <= 1'b0;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_tx_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    wb_debug_bridge_tx_ser u_tx_ser (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_ld),
        .i_data  (w_ld_dat),
        .i_count (w_ld_cnt),
        .i_ready (tx_ready_i),
        .o_valid (tx_valid_o),
        .o_data  (tx_data_o),
        .o_done  (w_tx_done)
    );

endmodule

// File: tb/tb_wb_debug_bridge.sv
// Scoreboard bench for wb_debug_bridge: expected tx bytes and bus transactions are queued by the stimulus.
module tb_wb_debug_bridge;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] addr_o, data_o, data_i;
    logic        ack_i;
    logic        busy_o, cpu_halt_o;

    logic        rdy_lvl, rdy_toggle;
    logic        slave_en;
    int          ack_delay;
    int          wait_cnt;
    logic [31:0] slave_rdata;
    int          cyc_cycles;

    logic [7:0]  tx_q[$];
    bus_t        bus_q[$];
    int          n_total = 0;
    int          n_pass = 0;

    wb_debug_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .addr_o(addr_o), .data_o(data_o), .data_i(data_i), .ack_i(ack_i),
        .busy_o(busy_o), .cpu_halt_o(cpu_halt_o)
    );

    always #5 clk = ~clk;

    // Wishbone slave: acks ack_delay cycles after strobe rises (0 = same cycle).
    assign ack_i  = cyc_o && slave_en && (wait_cnt >= ack_delay);
    assign data_i = slave_rdata;
    always @(posedge clk) begin
        if (!cyc_o || ack_i) wait_cnt <= 0;
        else                 wait_cnt <= wait_cnt + 1;
    end

    always @(posedge clk) begin
        #1;
        tx_ready_i = rdy_toggle ? ~tx_ready_i : rdy_lvl;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (cyc_o) cyc_cycles++;
        if (tx_valid_o && tx_ready_i) begin
            if (tx_q.size() == 0) check("tx_unexpected", {24'h0, tx_data_o}, 32'hFFFF_FFFF);
            else check("tx_byte", {24'h0, tx_data_o}, {24'h0, tx_q.pop_front()});
        end
        if (cyc_o && ack_i) begin
            check("stb_eq_cyc", {31'h0, stb_o}, 32'h1);
            if (bus_q.size() == 0) begin
                check("bus_unexpected", addr_o, 32'hFFFF_FFFF);
            end else begin
                bus_t e;
                e = bus_q.pop_front();
                check("bus_we", {31'h0, we_o}, {31'h0, e.we});
                check("bus_addr", addr_o, e.addr);
                if (e.we) check("bus_wdata", data_o, e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(posedge clk); #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic wait_done(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = !busy_o && tx_q.size() == 0 && bus_q.size() == 0;
        end
        check(name, {31'h0, done}, 32'h1);
    endtask

    task automatic wait_tx_valid(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = tx_valid_o;
        end
        check(name, {31'h0, seen}, 32'h1);
    endtask

    task automatic do_reset(input string name);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({name, "_cyc"},   {31'h0, cyc_o},      32'h0);
        check({name, "_txv"},   {31'h0, tx_valid_o}, 32'h0);
        check({name, "_busy"},  {31'h0, busy_o},     32'h0);
        rst = 1'b0;
    endtask

    initial begin
        int stb_len;
        rst = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00;
        rdy_lvl = 1'b1; rdy_toggle = 1'b0;
        slave_en = 1'b1; ack_delay = 0; slave_rdata = 32'h0; cyc_cycles = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cyc",  {31'h0, cyc_o},      32'h0);
        check("rst_we",   {31'h0, we_o},       32'h0);
        check("rst_txv",  {31'h0, tx_valid_o}, 32'h0);
        check("rst_busy", {31'h0, busy_o},     32'h0);
        check("rst_halt", {31'h0, cpu_halt_o}, 32'h0);
        rst = 1'b0;

        // 1: write with a 2-cycle slave
        ack_delay = 2;
        bus_q.push_back('{1'b1, 32'h8000_0000, 32'h0000_00A5});
        tx_q.push_back(8'h06);
        send_byte(8'h57); send_word(32'h8000_0000); send_word(32'h0000_00A5);
        wait_done("t1_done");
        check("t1_busy", {31'h0, busy_o}, 32'h0);

        // 2: zero-wait read, tx_ready toggling
        ack_delay = 0; slave_rdata = 32'hDEAD_BEEF; rdy_toggle = 1'b1;
        bus_q.push_back('{1'b0, 32'h0000_0010, 32'h0});
        tx_q.push_back(8'hDE); tx_q.push_back(8'hAD); tx_q.push_back(8'hBE); tx_q.push_back(8'hEF);
        send_byte(8'h52); send_word(32'h0000_0010);
        wait_done("t2_done");
        rdy_toggle = 1'b0; rdy_lvl = 1'b1;

        // 3: halt on/off, bad command
        tx_q.push_back(8'h06);
        send_byte(8'h48); send_byte(8'h01);
        wait_done("t3_h1_done");
        check("t3_halt1", {31'h0, cpu_halt_o}, 32'h1);
        tx_q.push_back(8'h06);
        send_byte(8'h48); send_byte(8'h00);
        wait_done("t3_h0_done");
        check("t3_halt0", {31'h0, cpu_halt_o}, 32'h0);
        stb_len = cyc_cycles;
        tx_q.push_back(8'h15);
        send_byte(8'h7A);
        wait_done("t3_nak_done");
        check("t3_no_bus", cyc_cycles, stb_len);

        // 4: slave never acks
        slave_en = 1'b0;
`ifdef WB_DEBUG_BRIDGE_TIMEOUT_EN
        tx_q.push_back(8'h15);
        send_byte(8'h52); send_word(32'h0000_0020);
        stb_len = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stb_o) break;
            stb_len++;
        end
        check("t4_stb_len", stb_len, 8);
        wait_done("t4_to_done");
`else
        send_byte(8'h52); send_word(32'h0000_0020);
        repeat (40) @(negedge clk);
        check("t4_stb_held", {31'h0, stb_o}, 32'h1);
        do_reset("t4_rst");
`endif

        // 5: reset during BUS, then during RESP
        send_byte(8'h52); send_word(32'h0000_0030);
        repeat (3) @(negedge clk);
        check("t5_in_bus", {31'h0, cyc_o}, 32'h1);
        do_reset("t5_rst_bus");
        slave_en = 1'b1; ack_delay = 0; slave_rdata = 32'h1234_5678; rdy_lvl = 1'b0;
        bus_q.push_back('{1'b0, 32'h0000_0040, 32'h0});
        send_byte(8'h52); send_word(32'h0000_0040);
        wait_tx_valid("t5_resp_seen");
        check("t5_resp_byte", {24'h0, tx_data_o}, 32'h12);
        do_reset("t5_rst_resp");
        rdy_lvl = 1'b1;
        bus_q.push_back('{1'b1, 32'h0000_0100, 32'h0BAD_CAFE});
        tx_q.push_back(8'h06);
        send_byte(8'h57); send_word(32'h0000_0100); send_word(32'h0BAD_CAFE);
        wait_done("t5_after_done");

        // 6: bytes during BUS and RESP are dropped
        ack_delay = 10; rdy_lvl = 1'b0;
        bus_q.push_back('{1'b1, 32'h0000_0200, 32'h5555_AAAA});
        tx_q.push_back(8'h06);
        send_byte(8'h57); send_word(32'h0000_0200); send_word(32'h5555_AAAA);
        send_byte(8'h52); send_byte(8'h48); send_byte(8'h01);
        wait_tx_valid("t6_resp_seen");
        send_byte(8'h57); send_byte(8'h48); send_byte(8'h01);
        rdy_lvl = 1'b1;
        wait_done("t6_w_done");
        check("t6_halt_kept", {31'h0, cpu_halt_o}, 32'h0);
        ack_delay = 1; slave_rdata = 32'hCAFE_F00D;
        bus_q.push_back('{1'b0, 32'h0000_0044, 32'h0});
        tx_q.push_back(8'hCA); tx_q.push_back(8'hFE); tx_q.push_back(8'hF0); tx_q.push_back(8'h0D);
        send_byte(8'h52); send_word(32'h0000_0044);
        wait_done("t6_r_done");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
